// File: rtl/mac_array_sched.sv
// mac_array_sched: control sequencer for an N x N weight-stationary systolic MAC array.
// Takes one matrix-multiply job per handshake. It loads N weight rows, streams T input
// columns, then flushes the pipeline with zero columns. It emits T result columns under
// a valid/ready handshake. Downstream backpressure freezes the whole array through arr_en.
// The block has no datapath: it drives only strobes and indices.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   job_valid/job_ready/job_t      job request handshake and column count
//   job_err                        one-cycle pulse when a job is rejected (t==0 or t>TMAX)
//   w_valid/w_ready/w_load/w_row   weight row handshake, latch strobe and row index
//   x_valid/x_ready/x_shift        input column handshake and real-column shift strobe
//   x_zero, x_col                  zero-column (flush) shift strobe, column index
//   arr_en                         global MAC array clock enable
//   res_capture                    datapath latches array output into the holding register
//   res_valid/res_ready/res_col    result handshake and held column index
//   busy, done                     not idle; one-cycle pulse at job completion
module mac_array_sched #(
  parameter int unsigned N    = 5,
  parameter int unsigned TMAX = 16,
  parameter int unsigned LAT  = 10,
  parameter int unsigned CW   = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [CW-1:0] job_t,
  output logic          job_err,
  input  logic          w_valid,
  output logic          w_ready,
  output logic          w_load,
  output logic [2:0]    w_row,
  input  logic          x_valid,
  output logic          x_ready,
  output logic          x_shift,
  output logic          x_zero,
  output logic [CW-1:0] x_col,
  output logic          arr_en,
  output logic          res_capture,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_col,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  localparam logic [CW-1:0] One     = CW'(1);
  localparam logic [CW-1:0] TMaxCw  = CW'(TMAX);
  localparam logic [2:0]    LastRow = 3'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   t_q, in_cnt_q, out_cnt_q, res_col_q;
  logic [2:0]      w_cnt_q;
  // Token pipe: a 1 marks a real column travelling through the array, 0 a flush column.
  logic [LAT-1:0]  tok_q;
  logic            res_valid_q, job_err_q;
  logic            stall, tok_in, job_take, job_ok;

  assign stall    = res_valid_q & ~res_ready;
  assign job_take = job_valid & (state_q == StIdle);
  assign job_ok   = (job_t != '0) && (job_t <= TMaxCw);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_ready = 1'b0;
    w_load  = 1'b0;
    arr_en  = 1'b0;
    x_zero  = 1'b0;
    tok_in  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (job_take && job_ok) state_d = StLoadW;
      end
      StLoadW: begin
        w_ready = 1'b1;
        w_load  = w_valid;
        if (w_valid && (w_cnt_q == LastRow)) state_d = StStream;
      end
      StStream: begin
        arr_en = x_valid & ~stall;
        tok_in = 1'b1;
        // Leave on the tick that shifts the last real column.
        if (arr_en && ((in_cnt_q + One) == t_q)) state_d = StDrain;
      end
      StDrain: begin
        arr_en = ~stall;
        x_zero = arr_en;
        if ((out_cnt_q == t_q) && (!res_valid_q || res_ready)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign job_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign job_err     = job_err_q;
  assign w_row       = w_cnt_q;
  assign x_shift     = arr_en & (state_q == StStream);
  assign x_ready     = x_shift;
  assign x_col       = in_cnt_q;
  assign res_capture = arr_en & tok_q[LAT-1];
  assign res_valid   = res_valid_q;
  assign res_col     = res_col_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      t_q         <= '0;
      w_cnt_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      tok_q       <= '0;
      res_valid_q <= 1'b0;
      res_col_q   <= '0;
      job_err_q   <= 1'b0;
    end else begin
      job_err_q <= job_take & ~job_ok;
      if (job_take && job_ok) begin
        t_q       <= job_t;
        w_cnt_q   <= '0;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        tok_q     <= '0;
      end
      if (w_load) w_cnt_q <= w_cnt_q + 3'd1;
      if (arr_en) tok_q <= {tok_q[LAT-2:0], tok_in};
      if (x_shift) in_cnt_q <= in_cnt_q + One;
      if (res_capture) begin
        res_valid_q <= 1'b1;
        res_col_q   <= out_cnt_q;
        out_cnt_q   <= out_cnt_q + One;
      end else if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_array_sched.sv
// Self-checking bench for mac_array_sched. Jobs are issued by a main process that pushes
// the expected result column sequence into a scoreboard queue. A negedge monitor pops it
// on every accepted result. Latency is modelled as "LAT enabled ticks after a column is
// shifted in, its result is captured". This is tracked with a queue of target tick numbers.
module tb_mac_array_sched;
  localparam int N    = 5;
  localparam int TMAX = 16;
  localparam int LAT  = 10;
  localparam int CW   = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [CW-1:0] job_t = '0;
  logic          job_err;
  logic          w_valid = 1'b0;
  logic          w_ready, w_load;
  logic [2:0]    w_row;
  logic          x_valid = 1'b0;
  logic          x_ready, x_shift, x_zero;
  logic [CW-1:0] x_col;
  logic          arr_en, res_capture, res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_col;
  logic          busy, done;

  mac_array_sched #(.N(N), .TMAX(TMAX), .LAT(LAT), .CW(CW)) dut (
    .CLK(CLK), .RST(RST),
    .job_valid(job_valid), .job_ready(job_ready), .job_t(job_t), .job_err(job_err),
    .w_valid(w_valid), .w_ready(w_ready), .w_load(w_load), .w_row(w_row),
    .x_valid(x_valid), .x_ready(x_ready), .x_shift(x_shift), .x_zero(x_zero), .x_col(x_col),
    .arr_en(arr_en), .res_capture(res_capture),
    .res_valid(res_valid), .res_ready(res_ready), .res_col(res_col),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Handshake activity in percent, applied one cycle after being changed.
  int p_w = 100, p_x = 100, p_r = 100;

  // Reference model state
  int exp_col[$];
  int lat_q[$];
  int tick = 0, cyc = 0;
  int next_w = 0, next_x = 0;
  int done_cnt = 0, err_cnt = 0, wr_cnt = 0;
  int first_w_cyc = 0, last_w_cyc = 0, first_x_cyc = 0, last_x_cyc = 0, last_cap_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    #1;
    w_valid   = ($urandom_range(99) < p_w);
    x_valid   = ($urandom_range(99) < p_x);
    res_ready = ($urandom_range(99) < p_r);
  end

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (!RST) begin
      if (w_ready) begin
        wr_cnt++;
        check("arr_en_in_load", arr_en, 0);
      end
      if (w_load) begin
        if (next_w == 0) first_w_cyc = cyc;
        last_w_cyc = cyc;
        check("w_row", w_row, next_w);
        next_w++;
      end
      if (x_shift) begin
        if (next_x == 0) first_x_cyc = cyc;
        last_x_cyc = cyc;
        check("x_col", x_col, next_x);
        check("x_ready_eq_shift", x_ready, 1);
        next_x++;
        lat_q.push_back(tick + LAT);
      end
      if (!x_valid) check("x_shift_without_x_valid", x_shift, 0);
      if (res_valid && !res_ready) check("arr_en_during_stall", arr_en, 0);
      if (res_capture) begin
        last_cap_cyc = cyc;
        if (lat_q.size() == 0) check("capture_unexpected", 1, 0);
        else check("capture_tick", tick, lat_q.pop_front());
      end
      if (res_valid && res_ready) begin
        if (exp_col.size() == 0) check("result_unexpected", 1, 0);
        else check("res_col", res_col, exp_col.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("results_left_at_done", exp_col.size(), 0);
      end
      if (job_err) err_cnt++;
      if (arr_en) tick++;
    end
  end

  task automatic issue_job(input int t);
    int g = 0;
    @(negedge CLK);
    while (!job_ready && g < 500) begin
      @(negedge CLK);
      g++;
    end
    check("job_ready_before_issue", job_ready, 1);
    next_w = 0;
    next_x = 0;
    if (t >= 1 && t <= TMAX) for (int k = 0; k < t; k++) exp_col.push_back(k);
    job_t     = CW'(t);
    job_valid = 1'b1;
    @(negedge CLK);
    job_valid = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int g  = 0;
    while (done_cnt == d0 && g < 3000) begin
      @(negedge CLK);
      g++;
    end
    check("done_pulses", done_cnt - d0, 1);
    @(negedge CLK);
    check("job_ready_after_done", job_ready, 1);
    check("done_one_cycle", done, 0);
    check("results_outstanding", exp_col.size(), 0);
    check("captures_outstanding", lat_q.size(), 0);
  endtask

  initial begin
    int g;
    int e0, w0;
    // Reset state
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_job_err", job_err, 0);
    check("rst_w_ready", w_ready, 0);

    // Basic t=3 job, all handshakes high
    issue_job(3);
    wait_done();
    check("w_load_span", last_w_cyc - first_w_cyc, N - 1);
    check("stream_after_load", first_x_cyc - last_w_cyc, 1);
    check("t3_shift_count", next_x, 3);

    // Result stall: res_ready low for four cycles starting with the first result
    issue_job(3);
    g = 0;
    while (!res_capture && g < 200) begin
      @(negedge CLK);
      g++;
    end
    check("stall_capture_seen", res_capture, 1);
    p_r = 0;
    repeat (4) begin
      @(negedge CLK);
      check("stall_res_valid", res_valid, 1);
      check("stall_res_col", res_col, 0);
      check("stall_no_capture", res_capture, 0);
    end
    p_r = 100;
    wait_done();

    // x_valid gap of two cycles mid-stream
    issue_job(5);
    g = 0;
    while (!x_shift && g < 200) begin
      @(negedge CLK);
      g++;
    end
    p_x = 0;
    repeat (2) begin
      @(negedge CLK);
      check("gap_arr_en", arr_en, 0);
      check("gap_x_shift", x_shift, 0);
      check("gap_x_ready", x_ready, 0);
    end
    p_x = 100;
    wait_done();

    // Rejected jobs
    e0 = err_cnt;
    w0 = wr_cnt;
    issue_job(0);
    issue_job(17);
    repeat (2) @(negedge CLK);
    check("err_pulses", err_cnt - e0, 2);
    check("err_no_w_ready", wr_cnt - w0, 0);
    check("err_job_ready", job_ready, 1);
    check("err_busy", busy, 0);

    // Reset in DRAIN with a held result
    p_r = 0;
    issue_job(3);
    g = 0;
    while (!res_valid && g < 200) begin
      @(negedge CLK);
      g++;
    end
    check("drain_res_valid", res_valid, 1);
    check("drain_busy", busy, 1);
    RST = 1'b1;
    @(negedge CLK);
    exp_col.delete();
    lat_q.delete();
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_job_ready", job_ready, 1);
    RST = 1'b0;
    p_r = 100;
    issue_job(1);
    wait_done();
    check("t1_shift_count", next_x, 1);

    // Full-size job; drain covers LAT ticks after the last shift
    issue_job(TMAX);
    wait_done();
    check("tmax_shift_count", next_x, TMAX);
    check("drain_latency", last_cap_cyc - last_x_cyc, LAT);

    // Randomized jobs and handshakes
    for (int j = 0; j < 8; j++) begin
      p_w = $urandom_range(30, 100);
      p_x = $urandom_range(30, 100);
      p_r = $urandom_range(30, 100);
      issue_job($urandom_range(1, TMAX));
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_array_sched.md
Name: mac_array_sched

Overview:
- Sequencer for the N×N weight-stationary systolic MAC array.
- Accepts one matrix-multiply job per handshake and paces weight-row loading into the array.
- Streams T input columns, flushes the pipeline with zero columns, and emits T result columns under a valid/ready handshake.
- Downstream backpressure freezes the whole array through a global enable. The block has no datapath of its own; it drives only control strobes and indices.

Parameters:
N, 5, array dimension (rows loaded, pipeline depth basis)
TMAX, 16, maximum input columns per job
LAT, 10, enabled-tick latency from x_shift of column k to that column's result at the array output
CW, 5, counter/index width (must hold TMAX)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
job_valid  in  1  job request
job_ready  out  1  high iff state IDLE
job_t  in  CW  input column count for the job
job_err  out  1  one-cycle pulse: job rejected
w_valid  in  1  weight row available
w_ready  out  1  scheduler accepts weight row
w_load  out  1  array latches weight row w_row this cycle
w_row  out  3  weight row index 0..N-1
x_valid  in  1  input column available
x_ready  out  1  input column consumed
x_shift  out  1  array shifts in real column this cycle
x_zero  out  1  array shifts in zero column (flush)
x_col  out  CW  index of column being shifted
arr_en  out  1  global clock enable to MAC array
res_capture  out  1  datapath latches array output into holding register
res_valid  out  1  result column in holding register valid
res_ready  in  1  downstream accepts result
res_col  out  CW  column index of held result
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (RST high at a CLK edge, any state, mid-job included): state IDLE, all counters 0, token pipe cleared, res_valid/done/job_err 0. The first cycle after reset has job_ready=1. An in-flight result is discarded.
- States are IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - On job_valid & job_ready: if job_t==0 or job_t>TMAX, pulse job_err next cycle and stay IDLE.
  - Otherwise latch t=job_t, clear counters, and go to LOAD_W.
- LOAD_W:
  - w_ready=1 and arr_en=0.
  - Each w_valid cycle: w_load=1, w_row=w_cnt, w_cnt++.
  - After row N-1 is accepted, go to STREAM.
- Stall: stall = res_valid & ~res_ready.
- STREAM:
  - arr_en = x_valid & ~stall; x_ready = x_shift = arr_en; x_col = in_cnt.
  - Each enabled tick pushes token=1 into an LAT-deep token pipe and increments in_cnt.
  - When in_cnt reaches t, go to DRAIN.
  - If x_valid=0 or stall, arr_en=0 and the array and token pipe hold.
- DRAIN:
  - arr_en = ~stall; x_zero = arr_en; tokens pushed are 0.
  - Exit to DONE when out_cnt==t and (res_valid==0 or res_ready==1).
- Token pipe:
  - Advances only on arr_en.
  - res_capture = arr_en & tail token.
  - On res_capture: res_valid<=1, res_col<=out_cnt, out_cnt++.
  - Else if res_valid & res_ready: res_valid<=0.
  - Capture and accept in the same cycle are legal (stall=0): back-to-back results.
- DONE: done=1 for one cycle, then IDLE. A job_valid in DONE is not accepted.
- No combinational path from res_ready to x_ready except through stall/arr_en. Counters never wrap within a job. In STREAM, in_cnt ≤ t.

Test Plan:
- N=5, LAT=10, job_t=3, w_valid/x_valid/res_ready constantly high:
  - w_load on 5 consecutive cycles with w_row 0..4.
  - x_shift on STREAM ticks 0,1,2.
  - res_capture at ticks 10,11,12; res_valid high ticks 11–13 with res_col 0,1,2.
  - done pulse once, then job_ready=1.
- Same job, res_ready low for ticks 11–14:
  - res_valid holds res_col=0 and arr_en=0 during the stall, with no extra captures.
  - After release, res_col 1,2 follow on consecutive cycles; the total of 3 results is unchanged.
- x_valid low for 2 cycles mid-STREAM:
  - arr_en, x_shift and x_ready low for those cycles.
  - Capture ticks shift by 2 cycles; res_col order is unchanged.
- job_t=0, then job_t=17:
  - job_err pulses each time; state stays IDLE; w_ready never asserts.
- RST asserted during DRAIN with res_valid=1:
  - Next cycle res_valid=0, busy=0, job_ready=1.
  - A new job_t=1 completes with exactly one result, res_col=0.
- job_t=TMAX=16, all handshakes high:
  - 16 results with res_col 0..15 in order, then done.
  - DRAIN lasts LAT ticks after the last x_shift.
